fir_mac_scheduler: RTL and testbench

- Time-multiplexed controller for the 37-tap symmetric FIR. It replaces 19 parallel multipliers with one shared booth multiplier.
- Stores input samples in a circular buffer and forms the folded pre-add (x[k]+x[36-k]) for each tap.
- Sequences the shared multiplier through all 19 folded taps, one start/done handshake per tap, and accumulates the scaled products.
- Sits between the sample source (valid/ready) and the output sink (valid/ready). Drives an external booth instance.

---
 rtl/fir_pkg.sv | 48 ++++
 rtl/fir_sample_ring.sv | 49 ++++
 rtl/fir_mac_scheduler.sv | 127 ++++++++++++
 tb/tb_fir_mac_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and coefficient table for the folded
// 37-tap symmetric FIR scheduler.
package fir_pkg;

    localparam int unsigned WL       = 14;              // sample / coefficient width
    localparam int unsigned MAC_WL   = 20;              // accumulator / output width
    localparam int unsigned TAP_NUM  = 37;              // filter length (odd, symmetric)
    localparam int unsigned FOLD_LEN = (TAP_NUM + 1) / 2;
    localparam int unsigned PTR_W    = 6;               // ring pointer width
    localparam int unsigned K_W      = 5;               // folded tap index width
    localparam int unsigned MUL_W    = 16;              // multiplier operand width
    localparam int unsigned PROD_W   = 32;              // multiplier product width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        ACC,
        OUT
    } state_t;

    // Folded coefficient c[k]; k = FOLD_LEN-1 is the centre tap.
    function automatic logic signed [WL-1:0] fir_coef(input logic [K_W-1:0] k);
        case (k)
            5'd0:    return -14'sd19;
            5'd1:    return -14'sd68;
            5'd2:    return  14'sd0;
            5'd3:    return  14'sd120;
            5'd4:    return  14'sd60;
            5'd5:    return -14'sd166;
            5'd6:    return -14'sd176;
            5'd7:    return  14'sd169;
            5'd8:    return  14'sd344;
            5'd9:    return -14'sd89;
            5'd10:   return -14'sd557;
            5'd11:   return -14'sd134;
            5'd12:   return  14'sd781;
            5'd13:   return  14'sd592;
            5'd14:   return -14'sd982;
            5'd15:   return -14'sd1588;
            5'd16:   return  14'sd1120;
            5'd17:   return  14'sd5819;
            5'd18:   return  14'sd8191;
            default: return  14'sd0;
        endcase
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// 37-entry circular sample buffer addressed by sample age.
// Ports: clk/rst_n; wr_en/wr_data push a new sample (becomes age 0);
// rd_idx_a/rd_idx_b select sample ages, rd_data_a/rd_data_b return them
// combinationally.
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WL-1:0]    wr_data,
    input  logic [PTR_W-1:0] rd_idx_a,
    input  logic [PTR_W-1:0] rd_idx_b,
    output logic [WL-1:0]    rd_data_a,
    output logic [WL-1:0]    rd_data_b
);

    logic [WL-1:0]    mem [TAP_NUM];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] wp_next;
    logic [PTR_W-1:0] addr_a;
    logic [PTR_W-1:0] addr_b;

    // Age j lives at (wp - j) mod TAP_NUM, without a divider.
    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] p,
                                              input logic [PTR_W-1:0] j);
        return (p >= j) ? p - j : p - j + PTR_W'(TAP_NUM);
    endfunction

    assign wp_next   = (wp == PTR_W'(TAP_NUM - 1)) ? '0 : wp + PTR_W'(1);
    assign addr_a    = slot(wp, rd_idx_a);
    assign addr_b    = slot(wp, rd_idx_b);
    assign rd_data_a = mem[addr_a];
    assign rd_data_b = mem[addr_b];

    // Pointer advances first so the new sample lands at age 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            for (int unsigned i = 0; i < TAP_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            wp           <= wp_next;
            mem[wp_next] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed controller for a 37-tap symmetric FIR using one external
// shared multiplier, one start/done handshake per folded tap.
// Ports: clk/rst_n; s_data/s_valid/s_ready sample input; m_data/m_valid/
// m_ready filter output; mul_start/mul_a/mul_b/mul_p/mul_done external
// multiplier handshake; busy is high whenever not idle.
module fir_mac_scheduler
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WL-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [MAC_WL-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              mul_start,
    output logic [MUL_W-1:0]  mul_a,
    output logic [MUL_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_p,
    input  logic              mul_done,
    output logic              busy
);

    state_t            state;
    logic [K_W-1:0]    k;
    logic [MAC_WL-1:0] acc;
    logic [MAC_WL-1:0] prod_slice;
    logic              accept;
    logic [PTR_W-1:0]  idx_a;
    logic [PTR_W-1:0]  idx_b;
    logic [WL-1:0]     x_a;
    logic [WL-1:0]     x_b;
    logic [WL:0]       pre_sum;
    logic [WL-1:0]     coef;
    logic              unused_mul_p;

    assign accept = (state == IDLE) && s_valid && s_ready;
    assign idx_a  = PTR_W'(k);
    assign idx_b  = PTR_W'(TAP_NUM - 1) - PTR_W'(k);
    assign coef   = fir_coef(k);

    // Folded pre-add; the centre tap has no partner.
    assign pre_sum = (k == K_W'(FOLD_LEN - 1)) ? {x_a[WL-1], x_a}
                                               : {x_a[WL-1], x_a} + {x_b[WL-1], x_b};

    // Only bits [2*WL-1 -: MAC_WL] of the product feed the accumulator.
    assign unused_mul_p = ^{mul_p[PROD_W-1:2*WL], mul_p[2*WL-MAC_WL-1:0]};

    fir_sample_ring u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_data   (s_data),
        .rd_idx_a  (idx_a),
        .rd_idx_b  (idx_b),
        .rd_data_a (x_a),
        .rd_data_b (x_b)
    );

    // Scheduler FSM with registered handshake and multiplier outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_data     <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            busy       <= 1'b0;
            k          <= '0;
            acc        <= '0;
            prod_slice <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= '0;
                        k       <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    mul_b     <= {{(MUL_W - WL - 1){pre_sum[WL]}}, pre_sum};
                    mul_a     <= {{(MUL_W - WL){coef[WL-1]}}, coef};
                    mul_start <= 1'b1;
                    state     <= MUL;
                end
                MUL: begin
                    // Start is a single-cycle pulse; done may coincide with it.
                    mul_start <= 1'b0;
                    if (mul_done) begin
                        prod_slice <= mul_p[2*WL-1 -: MAC_WL];
                        state      <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + prod_slice;
                    if (k == K_W'(FOLD_LEN - 1)) begin
                        state <= OUT;
                    end else begin
                        k     <= k + K_W'(1);
                        state <= LOAD;
                    end
                end
                OUT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        m_valid <= 1'b1;
                        m_data  <= acc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: behavioural multiplier with
// configurable latency, randomized traffic and an arithmetic FIR model.
module tb_fir_mac_scheduler;

    localparam int TAPS = 37;
    localparam int FOLD = 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic        mul_done;
    logic        busy;

    fir_mac_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_done  (mul_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int coef [FOLD] = '{-19, -68, 0, 120, 60, -166, -176, 169, 344, -89,
                        -557, -134, 781, 592, -982, -1588, 1120, 5819, 8191};

    // Stimulus controls, owned by the main initial block.
    int   mul_d       = 3;
    logic rnd_ready   = 1'b0;
    logic ready_force = 1'b1;
    logic junk_en     = 1'b0;

    // Behavioural multiplier: done arrives in the mul_d-th cycle after start.
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    int   rem;
    logic junk = 1'b0;

    assign op_a     = 32'(signed'(mul_a));
    assign op_b     = 32'(signed'(mul_b));
    assign mul_p    = op_a * op_b;
    assign mul_done = ((mul_d == 1) ? mul_start : (rem == 1)) || junk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rem <= 0;
        else if (mul_start) rem <= mul_d - 1;
        else if (rem > 0)   rem <= rem - 1;
    end

    // Stray done pulses, only while idle or presenting an output.
    always @(posedge clk) begin
        #1;
        junk = junk_en && rst_n && (!busy || m_valid) && ($urandom_range(0, 3) == 0);
    end

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_force;
    end

    // Reference model: newest sample at hist[0].
    int hist [TAPS];
    int exp_q [$];
    int got_q [$];
    int hs_count     = 0;
    int total_starts = 0;

    function automatic int model_out();
        longint sum = 0;
        longint pre;
        logic signed [19:0] w;
        for (int j = 0; j < FOLD; j++) begin
            pre = (j == FOLD - 1) ? longint'(hist[j])
                                  : longint'(hist[j]) + longint'(hist[TAPS - 1 - j]);
            sum += (longint'(coef[j]) * pre) >>> 8;
        end
        w = sum[19:0];
        return int'(w);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            got_q.delete();
            for (int i = 0; i < TAPS; i++) hist[i] = 0;
        end else begin
            if (mul_start) total_starts++;
            if (m_valid && m_ready) begin
                got_q.push_back(int'($signed(m_data)));
                hs_count++;
            end
            if (s_valid && s_ready) begin
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i - 1];
                hist[0] = int'($signed(s_data));
                exp_q.push_back(model_out());
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        repeat (3) tick();
        check("rst_s_ready",   s_ready,   1);
        check("rst_m_valid",   m_valid,   0);
        check("rst_m_data",    m_data,    0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a",     mul_a,     0);
        check("rst_mul_b",     mul_b,     0);
        check("rst_busy",      busy,      0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [13:0] v, input int gap);
        int n = 0;
        repeat (gap) tick();
        while (!s_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!s_ready) check("s_ready_timeout", s_ready, 1);
        s_data  = v;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_valid) && n < 5000) begin
            tick();
            n++;
        end
        check("idle_timeout", (busy || m_valid), 0);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
    endtask

    task automatic run_impulse(input string tag);
        send(14'h1FFF, 0);
        for (int i = 0; i < 40; i++) send(14'h0000, 0);
        wait_idle();
        compare_all(tag);
        check({tag, "_n"},  got_q.size(), 41);
        check({tag, "_0"},  got_q[0],  -608);
        check({tag, "_1"},  got_q[1],  -2176);
        check({tag, "_18"}, got_q[18], 262080);
        check({tag, "_36"}, got_q[36], -608);
        for (int i = 37; i <= 40; i++) check({tag, "_tail"}, got_q[i], 0);
    endtask

    logic [13:0] lat_vec [4];
    int          lat_ref [4];

    task automatic run_latency(input int d);
        int n;
        int s0;
        do_reset();
        mul_d = d;
        for (int i = 0; i < 4; i++) begin
            s0 = total_starts;
            send(lat_vec[i], 0);
            n = 0;
            while (!m_valid && n < 2000) begin
                tick();
                n++;
            end
            check("latency", n, 19 * (d + 2) + 1);
            wait_idle();
            check("start_pulses", total_starts - s0, 19);
        end
        compare_all("lat");
    endtask

    initial begin
        int n;
        int hs0;
        int s0;
        int f;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        for (int i = 0; i < 4; i++) lat_vec[i] = 14'($urandom_range(0, 16383));

        // Impulse response from reset.
        do_reset();
        run_impulse("impulse");

        // Output backpressure.
        ready_force = 1'b0;
        tick();
        tick();
        send(14'($urandom_range(0, 16383)), 0);
        n = 0;
        while (!m_valid && n < 1000) begin
            tick();
            n++;
        end
        check("bp_wait", m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data",  $signed(m_data), exp_q[exp_q.size() - 1]);
            check("bp_s_ready", s_ready, 0);
            check("bp_busy",    busy,    1);
            tick();
        end
        hs0 = hs_count;
        ready_force = 1'b1;
        repeat (5) tick();
        check("bp_handshakes", hs_count - hs0, 1);
        check("bp_m_valid_drop", m_valid, 0);
        compare_all("bp");

        // Random traffic with gaps, random sink stalls and stray done pulses.
        do_reset();
        mul_d     = 2;
        junk_en   = 1'b1;
        rnd_ready = 1'b1;
        for (int i = 0; i < 100; i++)
            send(14'($urandom_range(0, 16383)), $urandom_range(0, 3));
        wait_idle();
        compare_all("wrap");
        check("wrap_n", got_q.size(), 100);

        // Extreme samples sign-matched to the coefficients force accumulator wrap.
        rnd_ready = 1'b0;
        junk_en   = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            f = (36 - i <= 18) ? 36 - i : i;
            send((coef[f] < 0) ? 14'h2000 : 14'h1FFF, 0);
        end
        wait_idle();
        compare_all("ovf");

        // Multiplier latency extremes.
        run_latency(1);
        for (int i = 0; i < 4; i++) lat_ref[i] = got_q[i];
        run_latency(17);
        for (int i = 0; i < 4; i++) check("lat_same_data", got_q[i], lat_ref[i]);

        // Reset during tap 7 of sample 5, then replay the impulse.
        do_reset();
        mul_d = 3;
        for (int i = 0; i < 5; i++) send(14'($urandom_range(0, 16383)), 0);
        wait_idle();
        compare_all("pre_abort");
        check("pre_abort_n", got_q.size(), 5);
        s0 = total_starts;
        send(14'($urandom_range(0, 16383)), 0);
        n = 0;
        while (total_starts - s0 < 8 && n < 500) begin
            tick();
            n++;
        end
        check("abort_reach_tap7", total_starts - s0, 8);
        rst_n = 1'b0;
        tick();
        check("abort_m_valid", m_valid, 0);
        check("abort_busy",    busy,    0);
        check("abort_s_ready", s_ready, 1);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_valid) n++;
            tick();
        end
        check("abort_no_output", n, 0);
        run_impulse("replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
